// File: rtl/mem_stage.sv
// orion core memory-access stage: loads/stores over a valid/ready dmem port,
// load alignment and sign-extension, registered mem_wb_t bundle to writeback.
package orion_types;
  localparam int XLEN  = 32;
  localparam int ADDRW = 32;
  localparam int MASKW = 4;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      insn;
    logic [ADDRW-1:0] mem_addr;
    logic [MASKW-1:0] mem_rmask;
    logic [MASKW-1:0] mem_wmask;
    logic [XLEN-1:0]  mem_rdata;
    logic [XLEN-1:0]  mem_wdata;
  } debug_t;

  typedef struct packed {
    logic            valid;
    logic            is_load;
    logic            is_store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] rs2_v;
    logic [4:0]      rd_s;
    logic            rd_we;
    logic            is_csr_op;
    debug_t          debug;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic            rd_we;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] rd_v;
    logic            is_csr_op;
    debug_t          debug;
  } mem_wb_t;
endpackage

module mem_stage
  import orion_types::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  ex_mem_t          ex_mem_i,
  output logic             ex_mem_ready_o,
  output mem_wb_t          mem_wb_o,
  output logic             dmem_req_valid_o,
  input  logic             dmem_req_ready_i,
  output logic             dmem_req_we_o,
  output logic [ADDRW-1:0] dmem_req_addr_o,
  output logic [MASKW-1:0] dmem_req_wmask_o,
  output logic [XLEN-1:0]  dmem_req_wdata_o,
  input  logic             dmem_rsp_valid_i,
  input  logic [XLEN-1:0]  dmem_rsp_rdata_i,
  output logic             misaligned_o
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  state_e           state_q;
  mem_wb_t          wb_q;
  logic             misal_q;
  logic             we_q;
  logic [ADDRW-1:0] addr_q;
  logic [MASKW-1:0] wmask_q;
  logic [XLEN-1:0]  wdata_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_s_q;
  logic             rd_we_q;
  logic             csr_q;
  debug_t           dbg_q;

  logic [1:0]       off;
  logic [2:0]       f3;
  logic             mem_in;
  logic             misal_in;
  logic             go_in;
  logic [MASKW-1:0] lanes;
  logic [MASKW-1:0] wmask_in;
  logic [XLEN-1:0]  wdata_in;
  debug_t           dbg_in;

  function automatic logic [XLEN-1:0] extract(
    input logic [XLEN-1:0] rdata,
    input logic [1:0]      o,
    input logic [2:0]      fn
  );
    logic [XLEN-1:0] sh;
    sh = rdata >> {o, 3'b000};
    unique case (1'b1)
      fn[1]: extract = sh;
      fn[0]: extract = fn[2] ? {16'h0, sh[15:0]}
                             : {{16{sh[15]}}, sh[15:0]};
      default: extract = fn[2] ? {24'h0, sh[7:0]}
                               : {{24{sh[7]}}, sh[7:0]};
    endcase
  endfunction

  assign off      = ex_mem_i.alu_res[1:0];
  assign f3       = ex_mem_i.funct3;
  assign mem_in   = ex_mem_i.valid
                  & (ex_mem_i.is_load | ex_mem_i.is_store);
  assign misal_in = (f3[1:0] == 2'b01 && off[0])
                  | (f3[1] && off != 2'b00);
  assign go_in    = mem_in & ~misal_in;

  always_comb begin
    lanes    = 4'b0001 << off;
    wdata_in = {4{ex_mem_i.rs2_v[7:0]}};
    unique case (1'b1)
      f3[1]: begin
        lanes    = 4'b1111;
        wdata_in = ex_mem_i.rs2_v;
      end
      f3[0]: begin
        lanes    = 4'b0011 << off;
        wdata_in = {2{ex_mem_i.rs2_v[15:0]}};
      end
      default: ;
    endcase
    wmask_in = ex_mem_i.is_store ? lanes : '0;
    if (!ex_mem_i.is_store) wdata_in = '0;
    dbg_in           = ex_mem_i.debug;
    dbg_in.mem_addr  = ex_mem_i.alu_res;
    dbg_in.mem_rmask = ex_mem_i.is_load ? lanes : '0;
    dbg_in.mem_wmask = wmask_in;
    dbg_in.mem_rdata = '0;
    dbg_in.mem_wdata = wdata_in;
  end

  // While in REQ the request comes from the latches so it stays stable.
  always_comb begin
    dmem_req_valid_o = 1'b0;
    ex_mem_ready_o   = 1'b0;
    dmem_req_we_o    = we_q;
    dmem_req_addr_o  = {addr_q[ADDRW-1:2], 2'b00};
    dmem_req_wmask_o = wmask_q;
    dmem_req_wdata_o = wdata_q;
    if (state_q == IDLE) begin
      dmem_req_valid_o = go_in & ~rst_i;
      ex_mem_ready_o   = ~(go_in & ~dmem_req_ready_i);
      dmem_req_we_o    = ex_mem_i.is_store;
      dmem_req_addr_o  = {ex_mem_i.alu_res[ADDRW-1:2], 2'b00};
      dmem_req_wmask_o = wmask_in;
      dmem_req_wdata_o = wdata_in;
    end else if (state_q == REQ) begin
      dmem_req_valid_o = ~rst_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wb_q    <= '0;
      misal_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rd_s_q  <= '0;
      rd_we_q <= 1'b0;
      csr_q   <= 1'b0;
      dbg_q   <= '0;
    end else begin
      wb_q.valid <= 1'b0;
      misal_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ex_mem_i.valid && !mem_in) begin
            wb_q <= '{valid: 1'b1, rd_we: ex_mem_i.rd_we,
                      rd_s: ex_mem_i.rd_s, rd_v: ex_mem_i.alu_res,
                      is_csr_op: ex_mem_i.is_csr_op,
                      debug: ex_mem_i.debug};
          end else if (mem_in && misal_in) begin
            wb_q <= '{valid: 1'b1, rd_we: 1'b0,
                      rd_s: ex_mem_i.rd_s, rd_v: '0,
                      is_csr_op: ex_mem_i.is_csr_op,
                      debug: dbg_in};
            misal_q <= 1'b1;
          end else if (go_in) begin
            we_q    <= ex_mem_i.is_store;
            addr_q  <= ex_mem_i.alu_res;
            wmask_q <= wmask_in;
            wdata_q <= wdata_in;
            f3_q    <= f3;
            rd_s_q  <= ex_mem_i.rd_s;
            rd_we_q <= ex_mem_i.rd_we;
            csr_q   <= ex_mem_i.is_csr_op;
            dbg_q   <= dbg_in;
            if (!dmem_req_ready_i) begin
              state_q <= REQ;
            end else if (ex_mem_i.is_store) begin
              wb_q <= '{valid: 1'b1, rd_we: 1'b0,
                        rd_s: ex_mem_i.rd_s, rd_v: '0,
                        is_csr_op: ex_mem_i.is_csr_op,
                        debug: dbg_in};
            end else begin
              state_q <= RSP;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready_i) begin
            if (we_q) begin
              wb_q <= '{valid: 1'b1, rd_we: 1'b0, rd_s: rd_s_q,
                        rd_v: '0, is_csr_op: csr_q, debug: dbg_q};
              state_q <= IDLE;
            end else begin
              state_q <= RSP;
            end
          end
        end
        RSP: begin
          if (dmem_rsp_valid_i) begin
            wb_q.valid     <= 1'b1;
            wb_q.rd_we     <= rd_we_q;
            wb_q.rd_s      <= rd_s_q;
            wb_q.rd_v      <= extract(dmem_rsp_rdata_i, addr_q[1:0], f3_q);
            wb_q.is_csr_op <= csr_q;
            wb_q.debug     <= '{pc: dbg_q.pc, insn: dbg_q.insn,
                                mem_addr: dbg_q.mem_addr,
                                mem_rmask: dbg_q.mem_rmask,
                                mem_wmask: dbg_q.mem_wmask,
                                mem_rdata: dmem_rsp_rdata_i,
                                mem_wdata: dbg_q.mem_wdata};
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_wb_o     = wb_q;
  assign misaligned_o = misal_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, stores, loads, backpressure,
// misaligned suppression and reset while a load is outstanding.
module tb_mem_stage;
  import orion_types::*;

  logic             clk;
  logic             rst;
  ex_mem_t          ex;
  logic             ex_rdy;
  mem_wb_t          wb;
  logic             rq_v;
  logic             rq_rdy;
  logic             rq_we;
  logic [ADDRW-1:0] rq_addr;
  logic [MASKW-1:0] rq_wmask;
  logic [XLEN-1:0]  rq_wdata;
  logic             rs_v;
  logic [XLEN-1:0]  rs_data;
  logic             misal;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ex_mem_i         (ex),
    .ex_mem_ready_o   (ex_rdy),
    .mem_wb_o         (wb),
    .dmem_req_valid_o (rq_v),
    .dmem_req_ready_i (rq_rdy),
    .dmem_req_we_o    (rq_we),
    .dmem_req_addr_o  (rq_addr),
    .dmem_req_wmask_o (rq_wmask),
    .dmem_req_wdata_o (rq_wdata),
    .dmem_rsp_valid_i (rs_v),
    .dmem_rsp_rdata_i (rs_data),
    .misaligned_o     (misal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] r2, input logic [4:0] rd,
                        input logic we);
    ex           = '0;
    ex.valid     = 1'b1;
    ex.is_load   = ld;
    ex.is_store  = st;
    ex.funct3    = f3;
    ex.alu_res   = a;
    ex.rs2_v     = r2;
    ex.rd_s      = rd;
    ex.rd_we     = we;
  endtask

  // Load with request accepted at once and response 3 cycles later.
  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp);
    rq_rdy = 1'b1;
    set_op(1'b1, 1'b0, f3, a, 32'h0, 5'd7, 1'b1);
    #1;
    chk({tag, "_rqv"}, rq_v, 1);
    chk({tag, "_addr"}, rq_addr, {a[31:2], 2'b00});
    chk({tag, "_we"}, rq_we, 0);
    tick();
    ex.valid = 1'b0;
    rq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_wait_rdy"}, ex_rdy, 0);
      chk({tag, "_wait_v"}, wb.valid, 0);
      if (i < 2) tick();
    end
    rs_v    = 1'b1;
    rs_data = rd;
    tick();
    rs_v = 1'b0;
    chk({tag, "_v"}, wb.valid, 1);
    chk({tag, "_rdv"}, wb.rd_v, exp);
    chk({tag, "_rds"}, wb.rd_s, 7);
    chk({tag, "_rdy"}, ex_rdy, 1);
  endtask

  initial begin
    rst = 1'b1; ex = '0; rq_rdy = 1'b0; rs_v = 1'b0; rs_data = '0;
    tick();
    tick();
    chk("rst_valid", wb.valid, 0);
    chk("rst_misal", misal, 0);
    chk("rst_rqv", rq_v, 0);
    rst = 1'b0;

    // ALU passthrough
    set_op(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1);
    #1;
    chk("alu_rdy", ex_rdy, 1);
    chk("alu_rqv", rq_v, 0);
    tick();
    ex.valid = 1'b0;
    chk("alu_v", wb.valid, 1);
    chk("alu_rdv", wb.rd_v, 32'h1234);
    chk("alu_rds", wb.rd_s, 5);
    chk("alu_we", wb.rd_we, 1);
    tick();
    chk("bubble_v", wb.valid, 0);

    // SB at 0x1003
    rq_rdy = 1'b1;
    set_op(1'b0, 1'b1, 3'd0, 32'h1003, 32'hAABBCCDD, 5'd0, 1'b0);
    #1;
    chk("sb_rqv", rq_v, 1);
    chk("sb_addr", rq_addr, 32'h1000);
    chk("sb_mask", rq_wmask, 4'b1000);
    chk("sb_wdata", rq_wdata, 32'hDDDDDDDD);
    chk("sb_we", rq_we, 1);
    chk("sb_rdy", ex_rdy, 1);
    tick();
    ex.valid = 1'b0;
    chk("sb_v", wb.valid, 1);
    chk("sb_rdwe", wb.rd_we, 0);
    chk("sb_dbgmask", wb.debug.mem_wmask, 4'b1000);

    // SH at 0x1002
    set_op(1'b0, 1'b1, 3'd1, 32'h1002, 32'h11223344, 5'd0, 1'b0);
    #1;
    chk("sh_mask", rq_wmask, 4'b1100);
    chk("sh_wdata", rq_wdata, 32'h33443344);
    tick();
    ex.valid = 1'b0;
    chk("sh_v", wb.valid, 1);

    do_load("lb",  3'b000, 32'h2002, 32'h00F10000, 32'hFFFFFFF1);
    do_load("lbu", 3'b100, 32'h2002, 32'h00F10000, 32'h000000F1);
    do_load("lh",  3'b001, 32'h2002, 32'hBEEF0000, 32'hFFFFBEEF);
    do_load("lhu", 3'b101, 32'h2002, 32'hBEEF0000, 32'h0000BEEF);
    chk("lw_dbgrd", wb.debug.mem_rdata, 32'hBEEF0000);

    // LW with 4 cycles of request backpressure
    rq_rdy = 1'b0;
    set_op(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 5'd9, 1'b1);
    #1;
    chk("bp_rqv0", rq_v, 1);
    chk("bp_rdy0", ex_rdy, 0);
    tick();
    ex.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rqv", rq_v, 1);
      chk("bp_addr", rq_addr, 32'h4000);
      chk("bp_we", rq_we, 0);
      chk("bp_rdy", ex_rdy, 0);
      chk("bp_v", wb.valid, 0);
      tick();
    end
    rq_rdy = 1'b1;
    #1;
    chk("bp_rqv_acc", rq_v, 1);
    tick();
    rq_rdy = 1'b0;
    chk("bp_rsp_rqv", rq_v, 0);
    chk("bp_rsp_rdy", ex_rdy, 0);
    chk("bp_rsp_v", wb.valid, 0);
    rs_v = 1'b1; rs_data = 32'h12345678;
    tick();
    rs_v = 1'b0;
    chk("bp_done_v", wb.valid, 1);
    chk("bp_done_rdv", wb.rd_v, 32'h12345678);
    chk("bp_done_rds", wb.rd_s, 9);
    tick();
    chk("bp_after_v", wb.valid, 0);

    // Misaligned LH at 0x3001
    rq_rdy = 1'b1;
    set_op(1'b1, 1'b0, 3'b001, 32'h3001, 32'h0, 5'd3, 1'b1);
    #1;
    chk("mis_rqv", rq_v, 0);
    chk("mis_rdy", ex_rdy, 1);
    tick();
    ex.valid = 1'b0;
    chk("mis_v", wb.valid, 1);
    chk("mis_we", wb.rd_we, 0);
    chk("mis_flag", misal, 1);
    tick();
    chk("mis_flag_clr", misal, 0);
    chk("mis_v_clr", wb.valid, 0);

    // Misaligned SW at 0x5002
    set_op(1'b0, 1'b1, 3'b010, 32'h5002, 32'h0, 5'd0, 1'b0);
    #1;
    chk("misw_rqv", rq_v, 0);
    tick();
    ex.valid = 1'b0;
    chk("misw_flag", misal, 1);

    // Reset while waiting in RSP
    set_op(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 5'd4, 1'b1);
    tick();
    ex.valid = 1'b0;
    rq_rdy = 1'b0;
    chk("rr_rdy_rsp", ex_rdy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_rdy", ex_rdy, 1);
    chk("rr_v", wb.valid, 0);
    rs_v = 1'b1; rs_data = 32'hDEADBEEF;
    tick();
    rs_v = 1'b0;
    chk("rr_ign_v", wb.valid, 0);
    chk("rr_ign_rdy", ex_rdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the orion core. It sits between execute and writeback. It takes the execute result bundle, runs loads and stores against the data-memory port with a valid/ready request and response handshake, and aligns and sign-extends load data. It then registers the `mem_wb_t` bundle that the writeback stage consumes, and stalls execute while a memory transaction is outstanding.

## Interface
Parameters come from `orion_types`: `XLEN` = 32, `ADDRW` = 32, `MASKW` = 4 (byte-enable width).

Ports:
- `clk_i`  in  1  Core clock. The block uses this single clock only.
- `rst_i`  in  1  Reset. Synchronous, active-high.
- `ex_mem_i`  in  `ex_mem_t`  Execute bundle with these fields: `valid`, `is_load`, `is_store`, `funct3[2:0]`, `alu_res[XLEN]` (effective address or result), `rs2_v[XLEN]`, `rd_s`, `rd_we`, `is_csr_op`, `debug`.
- `ex_mem_ready_o`  out  1  High when this stage accepts `ex_mem_i` this cycle. Execute holds its bundle stable while this is low.
- `mem_wb_o`  out  `mem_wb_t`  Registered bundle to writeback: `valid`, `rd_we`, `rd_s`, `rd_v`, `is_csr_op`, `debug`.
- `dmem_req_valid_o`  out  1  Data-memory request valid.
- `dmem_req_ready_i`  in  1  Data-memory request accepted.
- `dmem_req_we_o`  out  1  1 = store, 0 = load.
- `dmem_req_addr_o`  out  `ADDRW`  Word-aligned address (`alu_res & ~3`).
- `dmem_req_wmask_o`  out  `MASKW`  Byte enables. Stores only; 0 for loads.
- `dmem_req_wdata_o`  out  `XLEN`  Store data, lane-replicated.
- `dmem_rsp_valid_i`  in  1  Load response valid. Stores get no response.
- `dmem_rsp_rdata_i`  in  `XLEN`  Load response word.
- `misaligned_o`  out  1  One-cycle pulse, registered with `mem_wb_o`, marking a suppressed misaligned access.

## Operation
- FSM states: `IDLE`, `REQ`, `RSP`.
- **IDLE, non-memory instruction** (`valid` and neither `is_load` nor `is_store`):
  - Accept immediately.
  - Next edge: `mem_wb_o` takes `valid`, `rd_we`, `rd_s`, `is_csr_op`, `debug`, and `rd_v = alu_res`.
- **IDLE, memory instruction:**
  - Drive `dmem_req_valid_o` combinationally from `ex_mem_i`.
  - If `dmem_req_ready_i` = 1: a store accepts and retires next edge; a load accepts, latches `rd_s`, `funct3`, `addr[1:0]`, `debug`, and goes to `RSP`.
  - If `dmem_req_ready_i` = 0: latch the request and go to `REQ`.
- **REQ:**
  - Drive the request from latched registers. `ex_mem_ready_o` = 0.
  - On accept, a store retires next edge and returns to `IDLE`; a load goes to `RSP`.
- **RSP:**
  - `ex_mem_ready_o` = 0. Wait for `dmem_rsp_valid_i`.
  - On response, next edge: `mem_wb_o.valid` = 1, `rd_v` = extracted load value, state returns to `IDLE`.
- **Load extraction:** shift `rdata >> (8*addr[1:0])`, then apply `funct3`:
  - LB (000): sign-extend the low byte. LBU (100): zero-extend the low byte.
  - LH (001): sign-extend the low half. LHU (101): zero-extend the low half.
  - LW (010): use the full word.
- **Store lanes:**
  - SB: `wmask = 4'b0001 << addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - SH: `wmask = 4'b0011 << addr[1:0]`, `wdata = {2{rs2[15:0]}}`.
  - SW: `wmask = 4'b1111`, `wdata = rs2`.
- **Misaligned access** (half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0):
  - No request is issued; accept immediately.
  - Next edge: `mem_wb_o.valid` = 1, `rd_we` = 0, `misaligned_o` = 1.
- **Debug fields:** `mem_addr` = `alu_res`. `mem_rmask` = byte lanes read (loads) or 0. `mem_wmask` = `dmem_req_wmask_o`. `mem_rdata` = raw response word. `mem_wdata` = `dmem_req_wdata_o`.
- `dmem_rsp_valid_i` is ignored in `IDLE` and `REQ`.

## Timing
- **Reset** (sync, on a clock edge with `rst_i` = 1):
  - State → `IDLE`.
  - All `mem_wb_o` fields → 0 (so `valid` = 0).
  - `misaligned_o` → 0. All latched request registers → 0.
  - `dmem_req_valid_o` = 0 while `rst_i` is high.
- **Reset mid-transaction:** an outstanding request or response is abandoned. The data memory is reset in the same cycle.
- **Latency:**
  - Non-memory instruction, store accepted on first cycle, and misaligned access: 1 cycle.
  - Load with request accepted at cycle N and response at cycle M ≥ N+1: `mem_wb_o.valid` at the edge after M.
- **Handshake rules:**
  - `ex_mem_ready_o` = 1 in `IDLE` unless the incoming op is memory and `dmem_req_ready_i` = 0. Accept with the request in the same cycle.
  - In `REQ` and `RSP`, `ex_mem_ready_o` = 0.
  - Once asserted, `dmem_req_valid_o` and its payload stay stable until `dmem_req_ready_i`.
  - At most one outstanding load.
- **Bubbles:** any cycle that does not complete an instruction registers `mem_wb_o.valid` = 0. An `ex_mem_i.valid` = 0 input also registers a bubble.
- **Response timing:** a response arriving in the same cycle as request acceptance is illegal; the data memory guarantees M ≥ N+1.

## Test plan
- **ALU passthrough:** ADD with `alu_res` = 0x1234, `rd_s` = 5, `rd_we` = 1 → next cycle `mem_wb_o` has `valid` = 1, `rd_v` = 0x1234, `rd_s` = 5.
- **Store lanes:** SB with addr 0x1003, rs2 = 0xAABBCCDD, `req_ready` = 1 → `addr` = 0x1000, `wmask` = 1000b, `wdata` = 0xDDDDDDDD, `we` = 1; retires next cycle with `rd_we` = 0.
- **Load sign/zero-extend:** LB at addr 0x2002, `rdata` = 0x00F10000, response 3 cycles after accept → `rd_v` = 0xFFFFFFF1; repeat as LBU → 0x000000F1. `ex_mem_ready_o` is low throughout the wait.
- **Backpressure:** LW with `req_ready` held low for 4 cycles → request payload stable all 4 cycles, FSM `REQ` → `RSP` → `IDLE`, exactly one `mem_wb_o.valid` pulse.
- **Misaligned access:** LH at 0x3001 → no `dmem_req_valid_o`; next cycle `valid` = 1, `rd_we` = 0, `misaligned_o` = 1 for 1 cycle.
- **Reset in RSP:** assert `rst_i` for 1 cycle while in `RSP`, then pulse `dmem_rsp_valid_i` → it is ignored; `mem_wb_o.valid` = 0 and `ex_mem_ready_o` = 1 after reset.
